// File: rtl/ldq_ring.sv
// Load queue ring: in-order allocation, out-of-order issue to the mem pipe,
// in-order retire, and ROB-id based flush that rewinds the tail.
module ldq_ring #(
  parameter int NUM_ENTRIES = 16,
  parameter int ALLOC_PORTS = 2,
  parameter int ROBID_W = 6,
  parameter int PKT_W = 32,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [ALLOC_PORTS-1:0]         alloc_valid_i,
  input  logic [ALLOC_PORTS*ROBID_W-1:0] alloc_robid_i,
  output logic                           alloc_ready_o,
  output logic [ALLOC_PORTS*IDX_W-1:0]   alloc_ldqid_o,
  input  logic                           iss_valid_i,
  input  logic [IDX_W-1:0]               iss_ldqid_i,
  input  logic [PKT_W-1:0]               iss_pkt_i,
  output logic                           pipe_req_o,
  output logic [IDX_W-1:0]               pipe_req_ldqid_o,
  output logic [PKT_W-1:0]               pipe_req_pkt_o,
  input  logic                           pipe_gnt_i,
  input  logic                           resp_valid_i,
  input  logic [IDX_W-1:0]               resp_ldqid_i,
  input  logic [1:0]                     resp_action_i,
  input  logic                           stq_wake_i,
  input  logic                           retire_valid_i,
  input  logic                           nuke_valid_i,
  input  logic [ROBID_W-1:0]             nuke_robid_i,
  output logic                           idle_o,
  output logic                           full_o,
  output logic [IDX_W:0]                 count_o
);

  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(NUM_ENTRIES);
  localparam logic [PTR_W-1:0] NPORT = PTR_W'(ALLOC_PORTS);

  typedef enum logic [2:0] {
    INV,
    WAIT_ISS,
    READY,
    IN_PIPE,
    WAIT_STQ,
    DONE
  } ent_st_e;

  ent_st_e            st_q  [NUM_ENTRIES];
  ent_st_e            st_d  [NUM_ENTRIES];
  logic [ROBID_W-1:0] rob_q [NUM_ENTRIES];
  logic [ROBID_W-1:0] rob_d [NUM_ENTRIES];
  logic [PKT_W-1:0]   pkt_q [NUM_ENTRIES];
  logic [PKT_W-1:0]   pkt_d [NUM_ENTRIES];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] head_idx;

  logic [IDX_W-1:0] alloc_idx [ALLOC_PORTS];
  logic [PTR_W-1:0] n_alloc;
  logic             alloc_fire;

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             grant_fire;
  logic             retire_fire;

  logic [NUM_ENTRIES-1:0] flush;
  logic                   fl_vld;
  logic [PTR_W-1:0]       fl_off;

  // a is the same age as n or younger, under wrap-bit ordering
  function automatic logic younger_eq(
    input logic [ROBID_W-1:0] a,
    input logic [ROBID_W-1:0] n
  );
    if (a[ROBID_W-1] == n[ROBID_W-1])
      return a[ROBID_W-2:0] >= n[ROBID_W-2:0];
    return a[ROBID_W-2:0] < n[ROBID_W-2:0];
  endfunction

  assign head_idx      = head_q[IDX_W-1:0];
  assign count         = tail_q - head_q;
  assign count_o       = count;
  assign idle_o        = (count == '0);
  assign full_o        = (count == DEPTH);
  assign alloc_ready_o = ((DEPTH - count) >= NPORT);

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_idx[i] = tail_q[IDX_W-1:0] + n_alloc[IDX_W-1:0];
      alloc_ldqid_o[i*IDX_W +: IDX_W] = alloc_idx[i];
      if (alloc_valid_i[i])
        n_alloc = n_alloc + PTR_W'(1);
    end
  end

  assign alloc_fire = alloc_ready_o & ~nuke_valid_i & (|alloc_valid_i);

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = head_idx;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (!sel_vld && st_q[head_idx + IDX_W'(k)] == READY) begin
        sel_vld = 1'b1;
        sel_idx = head_idx + IDX_W'(k);
      end
    end
  end

  assign pipe_req_o       = sel_vld;
  assign pipe_req_ldqid_o = sel_idx;
  assign pipe_req_pkt_o   = pkt_q[sel_idx];

  assign grant_fire  = sel_vld & pipe_gnt_i;
  assign retire_fire = retire_valid_i & (st_q[head_idx] == DONE);
  assign head_d      = head_q + PTR_W'(retire_fire);

  // the retiring head is already gone when the flush is evaluated
  always_comb begin
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      flush[j] = nuke_valid_i
               && (st_q[j] != INV)
               && younger_eq(rob_q[j], nuke_robid_i)
               && !(retire_fire && head_idx == IDX_W'(j));
    end
  end

  always_comb begin
    fl_vld = 1'b0;
    fl_off = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (!fl_vld && flush[head_d[IDX_W-1:0] + IDX_W'(k)]) begin
        fl_vld = 1'b1;
        fl_off = PTR_W'(k);
      end
    end
  end

  always_comb begin
    tail_d = tail_q;
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      st_d[j]  = st_q[j];
      rob_d[j] = rob_q[j];
      pkt_d[j] = pkt_q[j];
      case (st_q[j])
        WAIT_ISS: begin
          if (iss_valid_i && iss_ldqid_i == IDX_W'(j)) begin
            st_d[j]  = READY;
            pkt_d[j] = iss_pkt_i;
          end
        end
        READY: begin
          if (grant_fire && sel_idx == IDX_W'(j))
            st_d[j] = IN_PIPE;
        end
        IN_PIPE: begin
          if (resp_valid_i && resp_ldqid_i == IDX_W'(j)) begin
            case (resp_action_i)
              2'd0:    st_d[j] = DONE;
              2'd1:    st_d[j] = READY;
              2'd2:    st_d[j] = WAIT_STQ;
              default: st_d[j] = IN_PIPE;
            endcase
          end
        end
        WAIT_STQ: begin
          if (stq_wake_i)
            st_d[j] = READY;
        end
        DONE: begin
          if (retire_fire && head_idx == IDX_W'(j))
            st_d[j] = INV;
        end
        default: st_d[j] = st_q[j];
      endcase
    end
    if (alloc_fire) begin
      for (int i = 0; i < ALLOC_PORTS; i++) begin
        if (alloc_valid_i[i]) begin
          st_d[alloc_idx[i]]  = WAIT_ISS;
          rob_d[alloc_idx[i]] = alloc_robid_i[i*ROBID_W +: ROBID_W];
        end
      end
      tail_d = tail_q + n_alloc;
    end
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      if (flush[j])
        st_d[j] = INV;
    end
    if (fl_vld)
      tail_d = head_d + fl_off;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      for (int j = 0; j < NUM_ENTRIES; j++)
        st_q[j] <= INV;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      st_q   <= st_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rob_q <= rob_d;
    pkt_q <= pkt_d;
  end

  a_retire_done: assert property (
    @(posedge clk_i) disable iff (reset_i)
    retire_valid_i |-> (st_q[head_idx] == DONE)
  );

  a_alloc_ready: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (|alloc_valid_i) |-> alloc_ready_o
  );

endmodule

// File: tb/tb_ldq_ring.sv
// Directed bench for ldq_ring with an age-ordered queue model
// checked every negedge, plus literal spot checks.
module tb_ldq_ring;

  localparam int N = 16;

  localparam int S_WI = 1;
  localparam int S_RD = 2;
  localparam int S_IP = 3;
  localparam int S_WS = 4;
  localparam int S_DN = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  av = '0;
  logic [11:0] ar = '0;
  logic        iv = 1'b0;
  logic [3:0]  il = '0;
  logic [31:0] ip = '0;
  logic        gnt = 1'b0;
  logic        rv = 1'b0;
  logic [3:0]  rl = '0;
  logic [1:0]  ra = '0;
  logic        wake = 1'b0;
  logic        ret = 1'b0;
  logic        nv = 1'b0;
  logic [5:0]  nr = '0;

  logic        alloc_ready;
  logic [7:0]  alloc_ldqid;
  logic        pipe_req;
  logic [3:0]  pipe_ldqid;
  logic [31:0] pipe_pkt;
  logic        idle;
  logic        full;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  ldq_ring dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .alloc_valid_i    (av),
    .alloc_robid_i    (ar),
    .alloc_ready_o    (alloc_ready),
    .alloc_ldqid_o    (alloc_ldqid),
    .iss_valid_i      (iv),
    .iss_ldqid_i      (il),
    .iss_pkt_i        (ip),
    .pipe_req_o       (pipe_req),
    .pipe_req_ldqid_o (pipe_ldqid),
    .pipe_req_pkt_o   (pipe_pkt),
    .pipe_gnt_i       (gnt),
    .resp_valid_i     (rv),
    .resp_ldqid_i     (rl),
    .resp_action_i    (ra),
    .stq_wake_i       (wake),
    .retire_valid_i   (ret),
    .nuke_valid_i     (nv),
    .nuke_robid_i     (nr),
    .idle_o           (idle),
    .full_o           (full),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [5:0]  rob;
    logic [31:0] pkt;
  } ent_t;

  ent_t q[$];
  int   mhead = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_yeq(input logic [5:0] a, input logic [5:0] n);
    logic [5:0] d;
    d = a - n;
    return d < 6'd32;
  endfunction

  function automatic int m_sel();
    foreach (q[i]) if (q[i].st == S_RD) return i;
    return -1;
  endfunction

  function automatic int m_pos(input logic [3:0] id);
    int p;
    p = (int'(id) - mhead) & (N - 1);
    return (p < q.size()) ? p : -1;
  endfunction

  task automatic m_step();
    int  n, sel, p;
    bit  rdy;
    ent_t e;
    if (rst) begin
      q.delete();
      mhead = 0;
      return;
    end
    n   = q.size();
    rdy = (N - n) >= 2;
    sel = m_sel();
    if (wake)
      foreach (q[i]) if (q[i].st == S_WS) q[i].st = S_RD;
    if (rv) begin
      p = m_pos(rl);
      if (p >= 0 && q[p].st == S_IP) begin
        if (ra == 2'd0) q[p].st = S_DN;
        else if (ra == 2'd1) q[p].st = S_RD;
        else if (ra == 2'd2) q[p].st = S_WS;
      end
    end
    if (iv) begin
      p = m_pos(il);
      if (p >= 0 && q[p].st == S_WI) begin
        q[p].st  = S_RD;
        q[p].pkt = ip;
      end
    end
    if (gnt && sel >= 0) q[sel].st = S_IP;
    if (ret && q.size() > 0 && q[0].st == S_DN) begin
      void'(q.pop_front());
      mhead++;
    end
    if (nv) begin
      p = -1;
      foreach (q[i]) if (p < 0 && m_yeq(q[i].rob, nr)) p = i;
      if (p >= 0) while (q.size() > p) void'(q.pop_back());
    end else if (rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (av[i]) begin
          e.st  = S_WI;
          e.rob = ar[i*6 +: 6];
          e.pkt = '0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    int n, below, sel;
    n = q.size();
    chk("count", 32'(count), n);
    chk("idle", 32'(idle), (n == 0));
    chk("full", 32'(full), (n == N));
    chk("alloc_ready", 32'(alloc_ready), ((N - n) >= 2));
    below = 0;
    for (int i = 0; i < 2; i++) begin
      chk("alloc_ldqid", 32'(alloc_ldqid[i*4 +: 4]),
          (mhead + n + below) & (N - 1));
      if (av[i]) below++;
    end
    sel = m_sel();
    chk("pipe_req", 32'(pipe_req), (sel >= 0));
    if (sel >= 0) begin
      chk("pipe_ldqid", 32'(pipe_ldqid), (mhead + sel) & (N - 1));
      chk("pipe_pkt", pipe_pkt, q[sel].pkt);
    end
  endtask

  always @(negedge clk) if (!rst) compare_all();

  task automatic clr();
    av = '0; ar = '0; iv = 0; il = '0; ip = '0; gnt = 0;
    rv = 0; rl = '0; ra = '0; wake = 0; ret = 0; nv = 0; nr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    clr();
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic alloc2(input logic [5:0] r0, input logic [5:0] r1);
    av = 2'b11; ar = {r1, r0};
    cyc();
  endtask

  task automatic alloc1(input logic [5:0] r0);
    av = 2'b01; ar = {6'd0, r0};
    cyc();
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] p);
    iv = 1; il = id; ip = p;
    cyc();
  endtask

  task automatic resp(input logic [3:0] id, input logic [1:0] a);
    rv = 1; rl = id; ra = a;
    cyc();
  endtask

  task automatic complete(input logic [3:0] id, input logic [31:0] p);
    issue(id, p);
    gnt = 1;
    cyc();
    resp(id, 2'd0);
  endtask

  initial begin
    clr();
    do_reset();
    #1;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_pipe_req", 32'(pipe_req), 0);

    av = 2'b11; ar = {6'd4, 6'd3};
    #1;
    chk("lit_ldq0", 32'(alloc_ldqid[3:0]), 0);
    chk("lit_ldq1", 32'(alloc_ldqid[7:4]), 1);
    cyc();
    chk("lit_count2", 32'(count), 2);

    av = 2'b10; ar = {6'd5, 6'd0};
    #1;
    chk("lit_p1_ldq", 32'(alloc_ldqid[7:4]), 2);
    cyc();

    issue(4'd1, 32'hA1);
    issue(4'd0, 32'hA0);
    chk("lit_req_oldest", 32'(pipe_ldqid), 0);
    chk("lit_req_pkt", pipe_pkt, 32'hA0);
    gnt = 1;
    cyc();
    chk("lit_req_next", 32'(pipe_ldqid), 1);
    gnt = 1;
    cyc();
    chk("lit_req_none", 32'(pipe_req), 0);

    resp(4'd0, 2'd2);
    chk("lit_wstq_noreq", 32'(pipe_req), 0);
    wake = 1;
    cyc();
    chk("lit_wake_req", 32'(pipe_req), 1);
    chk("lit_wake_id", 32'(pipe_ldqid), 0);
    gnt = 1;
    cyc();
    resp(4'd0, 2'd0);
    resp(4'd1, 2'd3);
    resp(4'd1, 2'd1);
    gnt = 1;
    cyc();
    resp(4'd1, 2'd0);
    issue(4'd1, 32'hBAD);

    issue(4'd2, 32'hA2);
    gnt = 1;
    cyc();
    wake = 1; rv = 1; rl = 4'd2; ra = 2'd2;
    cyc();
    chk("lit_wake_race", 32'(pipe_req), 0);
    wake = 1;
    cyc();
    gnt = 1;
    cyc();
    resp(4'd2, 2'd0);

    for (int i = 0; i < 3; i++) begin
      ret = 1;
      cyc();
    end
    chk("lit_empty", 32'(idle), 1);
    alloc1(6'd8);
    for (int i = 0; i < 6; i++) alloc2(6'(9 + 2*i), 6'(10 + 2*i));
    chk("lit_count13", 32'(count), 13);
    av = 2'b11; ar = {6'd22, 6'd21};
    #1;
    chk("lit_wrap0", 32'(alloc_ldqid[3:0]), 0);
    chk("lit_wrap1", 32'(alloc_ldqid[7:4]), 1);
    cyc();
    chk("lit_ready15", 32'(alloc_ready), 0);
    chk("lit_full15", 32'(full), 0);

    do_reset();
    for (int i = 0; i < 7; i++) alloc2(6'(2*i), 6'(2*i + 1));
    chk("lit_ready14", 32'(alloc_ready), 1);
    alloc2(6'd14, 6'd15);
    chk("lit_full16", 32'(full), 1);
    chk("lit_ready16", 32'(alloc_ready), 0);
    chk("lit_count16", 32'(count), 16);

    do_reset();
    alloc2(6'd50, 6'd51);
    alloc2(6'd52, 6'd53);
    for (int i = 0; i < 4; i++) complete(4'(i), 32'(16 + i));
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      cyc();
    end
    alloc2(6'd62, 6'd63);
    alloc2(6'd0, 6'd1);
    chk("lit_count4", 32'(count), 4);
    nv = 1; nr = 6'd63; av = 2'b11; ar = {6'd21, 6'd20};
    cyc();
    chk("lit_nuke_count", 32'(count), 1);
    av = 2'b01;
    #1;
    chk("lit_nuke_tail", 32'(alloc_ldqid[3:0]), 5);
    av = '0;
    complete(4'd4, 32'hC4);
    ret = 1; nv = 1; nr = 6'd62;
    cyc();
    chk("lit_ret_nuke", 32'(count), 0);

    alloc2(6'd10, 6'd11);
    issue(4'd5, 32'hD5);
    issue(4'd6, 32'hD6);
    nv = 1; nr = 6'd10; gnt = 1;
    cyc();
    chk("lit_nuke_gnt", 32'(count), 0);
    alloc1(6'd20);
    complete(4'd5, 32'hE5);
    ret = 1; av = 2'b11; ar = {6'd22, 6'd21};
    cyc();
    chk("lit_ret_alloc", 32'(count), 2);
    nv = 1; nr = 6'd30;
    cyc();
    chk("lit_nuke_none", 32'(count), 2);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
